mp_banked_ram: RTL and testbench
================================

// Module: mp_banked_ram
// PURPOSE
//  Multi-port, word-interleaved banked SRAM; successor of the single-port RAM. Serves NUM_PORTS
//  req/gnt/rvalid masters (e.g. core instr + data + debug) in one cycle when they hit different banks.
//  Per-bank round-robin arbitration, byte-enable writes, fixed 1-cycle response latency.
// PARAMETERS
//  ADDR_WIDTH  32   byte-address width per port
//  DATA_WIDTH  32   word width; multiple of 8
//  NUM_WORDS   1024 total words; multiple of NUM_BANKS
//  NUM_BANKS   4    power of 2, >=1; bank = word_addr[log2(NUM_BANKS)-1:0]
//  NUM_PORTS   2    master ports, >=1
// PORTS
//  clk       in   1                        clock
//  rst_n     in   1                        async active-low reset
//  req_i     in   [NUM_PORTS]              request valid per port
//  addr_i    in   [NUM_PORTS][ADDR_WIDTH]  byte address; word_addr = addr >> log2(DATA_WIDTH/8)
//  we_i      in   [NUM_PORTS]              1 = write, 0 = read
//  wdata_i   in   [NUM_PORTS][DATA_WIDTH]  write data
//  be_i      in   [NUM_PORTS][DATA_WIDTH/8] byte enables (writes only)
//  gnt_o     out  [NUM_PORTS]              request accepted this cycle (combinational)
//  rvalid_o  out  [NUM_PORTS]              response valid, one cycle after grant
//  rdata_o   out  [NUM_PORTS][DATA_WIDTH]  read data, registered
// BEHAVIOUR
//  - Reset: gnt_o follows comb logic (0 with req_i=0); rvalid_o=0, rdata_o=0, all RR pointers=0.
//    Memory contents not reset. Reset mid-transaction drops pending responses (rvalid_o=0).
//  - Per bank, each cycle: requesters targeting that bank compete; grant the first requester at or
//    after the bank's RR pointer (wrapping at NUM_PORTS). On grant, pointer <= winner+1 (mod NUM_PORTS).
//    Pointer unchanged when bank idle. At most one grant per bank per cycle; a port gets >=1 grant
//    within NUM_PORTS cycles of holding req.
//  - gnt_o[p] in same cycle as req_i[p]; ungranted master holds req/addr/we/wdata/be stable.
//  - Granted write: bytes with be=1 updated at clock edge; be=0 bytes preserved; be=0 all = no-op.
//  - Granted read: rdata_o[p] = mem word at next edge, rvalid_o[p]=1 for that one cycle.
//  - Every granted request (read or write) yields rvalid_o=1 exactly one cycle later; for writes
//    rdata_o=0. Back-to-back grants -> rvalid_o stays high continuously.
//  - Read of a word written in the previous cycle returns new data (no bypass needed; write lands first).
//  - Out-of-range (word_addr >= NUM_WORDS): granted; write dropped; read returns 0 with rvalid.
//  - Address bits below word granularity ignored (no misalignment error).
//  - When rvalid_o[p]=0, rdata_o[p] holds 0.
// STRUCTURE
//  - Package mp_ram_pkg: BANK_SEL_W, WORD_OFF_W, BANK_DEPTH localparam functions; bank_idx/word_idx
//    helper functions.
//  - Sub-module rr_arbiter #(N) (req vector, ptr reg, one-hot gnt); one instance per bank.
//  - Bank storage: generate loop, NUM_BANKS arrays `mem` of BANK_DEPTH words (preloadable by
//    $readmemb per bank); per-port response regs track granted bank, we, and range flag.
// TESTING
//  1 Reset: rst_n=0 for 2 cycles with req_i=all 1 -> rvalid_o=0, rdata_o=0 throughout.
//  2 Port0 writes 0xDEAD_BEEF be=4'hF to 0x10, next cycle reads 0x10 -> rdata_o[0]=0xDEADBEEF,
//    rvalid 1 cycle after each gnt.
//  3 Byte enables: word 0x20=0x11223344, write 0xAABBCCDD be=4'b0101 -> readback 0x11BB33DD.
//  4 No conflict: port0 reads 0x00 (bank0), port1 reads 0x04 (bank1) same cycle -> gnt_o=2'b11,
//    both rvalid next cycle with correct data.
//  5 Conflict: both ports hold req to 0x40 for 4 cycles -> gnt_o sequence 01,10,01,10 from reset ptr.
//  6 Out-of-range: read addr 4*NUM_WORDS -> gnt=1, rvalid=1, rdata=0; write there corrupts nothing
//    (full-memory compare vs reference model).

Source files
------------

// File: rtl/mp_ram_pkg.sv
// Shared sizing helpers for the multi-port banked RAM.
// Maps word addresses onto (bank, row) for word-interleaved banks.
package mp_ram_pkg;

    // A select field is kept at least 1 bit wide so that a single-bank build still elaborates.
    function automatic int bank_sel_w(input int num_banks);
        return (num_banks > 1) ? $clog2(num_banks) : 1;
    endfunction

    function automatic int word_off_w(input int data_width);
        return (data_width > 8) ? $clog2(data_width / 8) : 0;
    endfunction

    function automatic int bank_depth(input int num_words, input int num_banks);
        return num_words / num_banks;
    endfunction

    function automatic int row_sel_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic longint unsigned bank_idx(input longint unsigned word_addr,
                                                 input int unsigned num_banks);
        return word_addr % 64'(num_banks);
    endfunction

    function automatic longint unsigned word_idx(input longint unsigned word_addr,
                                                 input int unsigned num_banks);
        return word_addr / 64'(num_banks);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer,
// then moves the pointer just past the winner. The pointer holds when idle.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);
    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] winner;
    logic             found;

    always_comb begin
        gnt    = '0;
        winner = ptr;
        found  = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && req[(int'(ptr) + i) % N]) begin
                gnt[(int'(ptr) + i) % N] = 1'b1;
                winner = PTR_W'((int'(ptr) + i) % N);
                found  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (found) begin
            ptr <= PTR_W'((int'(winner) + 1) % N);
        end
    end

endmodule

// File: rtl/mp_banked_ram.sv
// Multi-port word-interleaved banked SRAM with per-bank round-robin arbitration,
// byte-enable writes and a fixed one-cycle response for every granted request.
module mp_banked_ram
    import mp_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WORDS  = 1024,
    parameter int NUM_BANKS  = 4,
    parameter int NUM_PORTS  = 2
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic [NUM_PORTS-1:0]                     req_i,
    input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]     addr_i,
    input  logic [NUM_PORTS-1:0]                     we_i,
    input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]     wdata_i,
    input  logic [NUM_PORTS-1:0][DATA_WIDTH/8-1:0]   be_i,
    output logic [NUM_PORTS-1:0]                     gnt_o,
    output logic [NUM_PORTS-1:0]                     rvalid_o,
    output logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]     rdata_o
);
    localparam int BANK_W = bank_sel_w(NUM_BANKS);
    localparam int OFF_W  = word_off_w(DATA_WIDTH);
    localparam int DEPTH  = bank_depth(NUM_WORDS, NUM_BANKS);
    localparam int ROW_W  = row_sel_w(DEPTH);
    localparam int BE_W   = DATA_WIDTH / 8;

    logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] word_addr;
    logic [NUM_PORTS-1:0][BANK_W-1:0]     bank;
    logic [NUM_PORTS-1:0][ROW_W-1:0]      row;
    logic [NUM_PORTS-1:0]                 in_range;
    logic [NUM_BANKS-1:0][NUM_PORTS-1:0]  bank_req;
    logic [NUM_BANKS-1:0][NUM_PORTS-1:0]  bank_gnt;
    logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] bank_rdata;
    logic [NUM_PORTS-1:0][BANK_W-1:0]     resp_bank;
    logic [NUM_PORTS-1:0]                 resp_rd;

    // Sub-word address bits are dropped here, so misaligned addresses simply hit the containing word.
    always_comb begin
        word_addr = '0;
        bank      = '0;
        row       = '0;
        in_range  = '0;
        bank_req  = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            word_addr[p] = addr_i[p] >> OFF_W;
            bank[p]      = BANK_W'(bank_idx(64'(word_addr[p]), NUM_BANKS));
            row[p]       = ROW_W'(word_idx(64'(word_addr[p]), NUM_BANKS));
            in_range[p]  = (64'(word_addr[p]) < 64'(NUM_WORDS));
            bank_req[int'(bank[p])][p] = req_i[p];
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [DATA_WIDTH-1:0] mem [DEPTH];
        logic [DATA_WIDTH-1:0] rd_q;
        logic [ROW_W-1:0]      sel_row;
        logic [DATA_WIDTH-1:0] sel_wdata;
        logic [BE_W-1:0]       sel_be;
        logic                  do_wr;
        logic                  do_rd;

        rr_arbiter #(.N(NUM_PORTS)) u_arb (
            .clk   (clk),
            .rst_n (rst_n),
            .req   (bank_req[b]),
            .gnt   (bank_gnt[b])
        );

        // Out-of-range winners are still granted but never touch the array.
        always_comb begin
            sel_row   = '0;
            sel_wdata = '0;
            sel_be    = '0;
            do_wr     = 1'b0;
            do_rd     = 1'b0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (bank_gnt[b][p]) begin
                    sel_row   = row[p];
                    sel_wdata = wdata_i[p];
                    sel_be    = be_i[p];
                    do_wr     = we_i[p] && in_range[p];
                    do_rd     = !we_i[p] && in_range[p];
                end
            end
        end

        always_ff @(posedge clk) begin
            if (do_wr) begin
                for (int k = 0; k < BE_W; k++) begin
                    if (sel_be[k]) begin
                        mem[sel_row][8*k +: 8] <= sel_wdata[8*k +: 8];
                    end
                end
            end
            if (do_rd) begin
                rd_q <= mem[sel_row];
            end
        end

        assign bank_rdata[b] = rd_q;
    end

    always_comb begin
        gnt_o = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            gnt_o = gnt_o | bank_gnt[b];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_o  <= '0;
            resp_bank <= '0;
            resp_rd   <= '0;
        end else begin
            rvalid_o  <= gnt_o;
            resp_bank <= bank;
            resp_rd   <= gnt_o & ~we_i & in_range;
        end
    end

    // Only in-range reads expose bank data; writes and out-of-range reads return zero.
    always_comb begin
        rdata_o = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (resp_rd[p]) begin
                rdata_o[p] = bank_rdata[resp_bank[p]];
            end
        end
    end

endmodule

// File: tb/tb_mp_banked_ram.sv
// Self-checking bench for mp_banked_ram: directed scenarios plus a randomized
// phase, all checked against a word-array reference model of the banked RAM.
module tb_mp_banked_ram;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NW = 1024;
    localparam int NB = 4;
    localparam int NP = 2;

    logic                    clk;
    logic                    rst_n;
    logic [NP-1:0]           req;
    logic [NP-1:0][AW-1:0]   addr;
    logic [NP-1:0]           we;
    logic [NP-1:0][DW-1:0]   wdata;
    logic [NP-1:0][DW/8-1:0] be;
    logic [NP-1:0]           gnt;
    logic [NP-1:0]           rvalid;
    logic [NP-1:0][DW-1:0]   rdata;

    logic [DW-1:0] ref_mem [NW];
    int            ptr_m [NB];
    logic [NP-1:0] last_gnt;
    int            total;
    int            bad;

    mp_banked_ram #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NUM_WORDS  (NW),
        .NUM_BANKS  (NB),
        .NUM_PORTS  (NP)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_i    (req),
        .addr_i   (addr),
        .we_i     (we),
        .wdata_i  (wdata),
        .be_i     (be),
        .gnt_o    (gnt),
        .rvalid_o (rvalid),
        .rdata_o  (rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_port(input int p, input logic r, input logic [AW-1:0] a,
                            input logic w, input logic [DW-1:0] d, input logic [3:0] e);
        req[p]   = r;
        addr[p]  = a;
        we[p]    = w;
        wdata[p] = d;
        be[p]    = e;
    endtask

    task automatic idle();
        for (int p = 0; p < NP; p++) set_port(p, 1'b0, '0, 1'b0, '0, 4'h0);
    endtask

    // One clock of traffic: predict grants/responses from the model, then compare.
    task automatic cycle(input string tag);
        logic [NP-1:0]         eg;
        logic [NP-1:0]         nv;
        logic [NP-1:0][DW-1:0] nd;
        int                    wa [NP];
        eg = '0;
        nv = '0;
        nd = '0;
        for (int p = 0; p < NP; p++) wa[p] = int'(addr[p] >> 2);
        for (int b = 0; b < NB; b++) begin
            int first;
            first = -1;
            for (int k = 0; k < NP; k++) begin
                int p;
                p = (ptr_m[b] + k) % NP;
                if (first < 0 && req[p] && (wa[p] % NB) == b) first = p;
            end
            if (first >= 0) begin
                eg[first] = 1'b1;
                ptr_m[b]  = (first + 1) % NP;
            end
        end
        for (int p = 0; p < NP; p++) begin
            if (eg[p]) begin
                nv[p] = 1'b1;
                if (!we[p] && wa[p] < NW) nd[p] = ref_mem[wa[p]];
            end
        end
        for (int p = 0; p < NP; p++) begin
            if (eg[p] && we[p] && wa[p] < NW) begin
                for (int i = 0; i < DW/8; i++) begin
                    if (be[p][i]) ref_mem[wa[p]][8*i +: 8] = wdata[p][8*i +: 8];
                end
            end
        end
        @(negedge clk);
        last_gnt = gnt;
        chk($sformatf("%s:gnt", tag), 64'(gnt), 64'(eg));
        @(posedge clk);
        #1;
        chk($sformatf("%s:rvalid", tag), 64'(rvalid), 64'(nv));
        chk($sformatf("%s:rdata", tag), 64'(rdata), 64'(nd));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '1;
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("reset:rvalid", 64'(rvalid), 64'h0);
            chk("reset:rdata", 64'(rdata), 64'h0);
        end
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        for (int b = 0; b < NB; b++) ptr_m[b] = 0;
        @(posedge clk);
        #1;
        chk("reset:idle_rvalid", 64'(rvalid), 64'h0);
    endtask

    task automatic dump_all(input string tag);
        for (int k = 0; k < NW / 2; k++) begin
            set_port(0, 1'b1, 32'(8*k),     1'b0, '0, 4'h0);
            set_port(1, 1'b1, 32'(8*k + 4), 1'b0, '0, 4'h0);
            cycle(tag);
        end
        idle();
    endtask

    initial begin
        logic [NP-1:0] seq [4];
        total    = 0;
        bad      = 0;
        last_gnt = '0;
        idle();
        for (int p = 0; p < NP; p++) addr[p] = 32'h40;
        do_reset();

        // Fill every word so later reads never see uninitialised storage.
        for (int k = 0; k < NW / 2; k++) begin
            set_port(0, 1'b1, 32'(8*k),     1'b1, $urandom, 4'hF);
            set_port(1, 1'b1, 32'(8*k + 4), 1'b1, $urandom, 4'hF);
            cycle("init");
        end
        idle();

        set_port(0, 1'b1, 32'h10, 1'b1, 32'hDEAD_BEEF, 4'hF);
        cycle("t2w");
        set_port(0, 1'b1, 32'h10, 1'b0, '0, 4'h0);
        cycle("t2r");
        chk("t2:rdata0", 64'(rdata[0]), 64'hDEAD_BEEF);
        chk("t2:rvalid0", 64'(rvalid[0]), 64'h1);

        set_port(0, 1'b1, 32'h20, 1'b1, 32'h1122_3344, 4'hF);
        cycle("t3w1");
        set_port(0, 1'b1, 32'h20, 1'b1, 32'hAABB_CCDD, 4'b0101);
        cycle("t3w2");
        set_port(0, 1'b1, 32'h22, 1'b0, '0, 4'h0);
        cycle("t3r");
        chk("t3:rdata0", 64'(rdata[0]), 64'h11BB_33DD);

        set_port(0, 1'b1, 32'h00, 1'b0, '0, 4'h0);
        set_port(1, 1'b1, 32'h04, 1'b0, '0, 4'h0);
        cycle("t4");
        chk("t4:gnt", 64'(last_gnt), 64'h3);
        chk("t4:rvalid", 64'(rvalid), 64'h3);

        // A read granted right before reset must not produce a response.
        idle();
        set_port(0, 1'b1, 32'h10, 1'b0, '0, 4'h0);
        @(negedge clk);
        do_reset();

        seq[0] = 2'b01;
        seq[1] = 2'b10;
        seq[2] = 2'b01;
        seq[3] = 2'b10;
        set_port(0, 1'b1, 32'h40, 1'b0, '0, 4'h0);
        set_port(1, 1'b1, 32'h40, 1'b0, '0, 4'h0);
        for (int i = 0; i < 4; i++) begin
            cycle("t5");
            chk($sformatf("t5:gnt_seq%0d", i), 64'(last_gnt), 64'(seq[i]));
        end
        idle();

        set_port(0, 1'b1, 32'(4*NW), 1'b0, '0, 4'h0);
        cycle("t6r");
        chk("t6:gnt0", 64'(last_gnt[0]), 64'h1);
        chk("t6:rvalid0", 64'(rvalid[0]), 64'h1);
        chk("t6:rdata0", 64'(rdata[0]), 64'h0);
        set_port(0, 1'b1, 32'(4*NW),     1'b1, $urandom, 4'hF);
        set_port(1, 1'b1, 32'(4*NW + 4), 1'b1, $urandom, 4'hF);
        cycle("t6w");
        idle();
        dump_all("t6dump");

        for (int n = 0; n < 400; n++) begin
            for (int p = 0; p < NP; p++) begin
                if (!(req[p] && !last_gnt[p])) begin
                    int wa;
                    wa = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, NW + 7))
                                                     : int'($urandom_range(0, 11));
                    set_port(p, $urandom_range(0, 3) != 0,
                             32'(wa * 4 + int'($urandom_range(0, 3))),
                             1'($urandom_range(0, 1)), $urandom, 4'($urandom));
                end
            end
            cycle("rand");
        end
        idle();
        dump_all("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
